violation_ticket_unit: RTL and testbench
========================================

// Module: violation_ticket_unit
// PURPOSE
//  Downstream of the intersection simulator: consumes red-light violation events (car removed
//  from a road while that road is red) and issues escalating fines as tickets.
//  Keeps a per-plate offence counter that is wiped at the daily rollover.
//  Buffers tickets in a FIFO drained by a valid/ready consumer (ticket printer / display).
// PARAMETERS
//  PLATE_W     5    plate width; counter table has 2**PLATE_W entries
//  CNT_W       4    per-plate offence counter width, saturating at 2**CNT_W-1
//  FIFO_DEPTH  8    ticket FIFO entries (power of two)
//  BASE_FINE   10   fine unit; fine = BASE_FINE*(prior_offences+1)
//  FINE_W      12   ticket fine width (must hold BASE_FINE*2**CNT_W)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous, active-low reset
//  viol_valid   in   1        one-cycle violation event strobe
//  viol_plate   in   PLATE_W  offending plate
//  viol_road    in   1        0 = road A, 1 = road B
//  day_clear    in   1        one-cycle pulse at the 11:59:59 PM -> 12:00:00 AM rollover
//  tkt_valid    out  1        FIFO head valid
//  tkt_ready    in   1        consumer accepts head when tkt_valid & tkt_ready
//  tkt_plate    out  PLATE_W  head ticket plate
//  tkt_road     out  1        head ticket road
//  tkt_fine     out  FINE_W   head ticket fine
//  total_fines  out  16       sum of fines pushed since reset/day_clear, saturating at 65535
//  drop_count   out  8        tickets lost to a full FIFO, saturating at 255, never day-cleared
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs 0; counter table all 0; FIFO empty; pipeline invalid.
//   - Reset mid-operation discards in-flight events and buffered tickets.
//  Pipeline
//   - S1 latches plate/road/valid.
//   - S2 reads count c (with forwarding), computes fine = BASE_FINE*(c+1), writes sat(c+1), pushes ticket.
//   - Latency: viol_valid at edge N -> tkt_valid=1 after edge N+2 when FIFO empty.
//   - Throughput: one event per cycle.
//   - Back-to-back events on the same plate must see the updated count (S2 -> S1 forward).
//     Example: three consecutive events on plate 7 give fines 10, 20, 30.
//  Saturation
//   - Count stuck at 2**CNT_W-1 -> every further fine = BASE_FINE*2**CNT_W (160 at defaults).
//  FIFO
//   - Push only from S2.
//   - Full and no pop: ticket dropped, drop_count++; the counter increment still happens, total_fines unchanged.
//   - Full with simultaneous pop: push accepted.
//   - Empty: tkt_valid=0, tkt_* hold last values.
//   - While tkt_valid & !tkt_ready, tkt_* are stable.
//   - Pointers wrap modulo FIFO_DEPTH; separate occupancy count distinguishes full from empty.
//  total_fines
//   - Adds the fine in the same cycle a push is accepted; saturates at 65535.
//  day_clear
//   - Zeros counter table and total_fines at the next edge. FIFO contents and drop_count are retained.
//   - Event in S2 on the clear edge: its ticket is still pushed at the pre-clear fine; its counter write is discarded; total_fines ends 0.
//   - Event entering S1 with day_clear: treated as first offence (fine BASE_FINE, count -> 1).
//  Idle
//   - viol_plate/viol_road are ignored when viol_valid=0.
//   - No combinational path from viol_* to tkt_*.
// STRUCTURE
//  - Shared package: PLATE_W, road encoding (ROAD_A=0, ROAD_B=1), BASE_FINE, FINE_W, and a ticket struct {plate, road, fine}.
//  - One sub-module: ticket_fifo (parameterised sync FIFO, valid/ready pop, full/empty, push/pop same cycle).
//  - Counter table, forwarding and fine arithmetic stay in this module.
// TESTING
//  1. Reset then a single event plate 5 road A, tkt_ready=1 -> tkt_valid at +2 cycles, fine=10, total_fines=10.
//  2. Plate 9 on four consecutive cycles -> fines 10,20,30,40; total_fines=100.
//  3. Plate 3 twenty times with ready=1 -> fines 10..150, then 160 for the 16th onward; total_fines saturation is not reached.
//  4. tkt_ready=0, 10 distinct events -> 8 tickets held, drop_count=2, head stable;
//     then ready=1 -> 8 tickets in order; a push coinciding with a pop while full is accepted.
//  5. Plate 4 twice, then day_clear, then plate 4 -> fines 10,20,10; total_fines=10; FIFO keeps the earlier tickets.
//  6. Assert rst_n=0 mid-burst with 3 queued tickets -> tkt_valid=0 immediately;
//     after release, the next plate-4 event fines 10.

Source files
------------

// File: rtl/violation_ticket_unit_pkg.sv
// Shared types and constants for the red-light violation ticket unit.
package violation_ticket_unit_pkg;
  localparam int PLATE_W    = 5;
  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int BASE_FINE  = 10;
  localparam int FINE_W     = 12;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

  typedef struct packed {
    logic [PLATE_W-1:0] plate;
    logic               road;
    logic [FINE_W-1:0]  fine;
  } ticket_t;

  // Fine for an offender with c prior offences.
  function automatic logic [FINE_W-1:0] fine_of(input logic [CNT_W-1:0] c);
    return FINE_W'(BASE_FINE) * (FINE_W'(c) + FINE_W'(1));
  endfunction
endpackage

// File: rtl/violation_ticket_unit_if.sv
// Violation event input and ticket valid/ready output bundle.
interface violation_ticket_unit_if;
  import violation_ticket_unit_pkg::*;

  logic               viol_valid;
  logic [PLATE_W-1:0] viol_plate;
  logic               viol_road;
  logic               tkt_valid;
  logic               tkt_ready;
  logic [PLATE_W-1:0] tkt_plate;
  logic               tkt_road;
  logic [FINE_W-1:0]  tkt_fine;

  modport master (
    output viol_valid, viol_plate, viol_road, tkt_ready,
    input  tkt_valid, tkt_plate, tkt_road, tkt_fine
  );

  modport slave (
    input  viol_valid, viol_plate, viol_road, tkt_ready,
    output tkt_valid, tkt_plate, tkt_road, tkt_fine
  );
endinterface

// File: rtl/violation_ticket_unit_ticket_fifo.sv
// Synchronous FIFO with valid/ready pop; when empty the output keeps showing the last popped entry.
module ticket_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic         accept_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, head_idx;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == (AW+1)'(DEPTH));
    pop      = !empty && ready_i;
    accept_o = push_i && (!full || pop);
    valid_o  = !empty;
    // Slot rd-1 is the last popped entry and is never rewritten while empty.
    head_idx = empty ? rd_q - AW'(1) : rd_q;
    data_o   = mem_q[head_idx];
    wr_d     = accept_o ? wr_q + AW'(1) : wr_q;
    rd_d     = pop ? rd_q + AW'(1) : rd_q;
    cnt_d    = cnt_q + (AW+1)'(accept_o) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (accept_o) mem_q[wr_q] <= data_i;
    end
  end
endmodule

// File: rtl/violation_ticket_unit.sv
// Two-stage violation pipeline: per-plate offence counters, escalating fines, ticket FIFO.
module violation_ticket_unit
  import violation_ticket_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    day_clear_i,
  violation_ticket_unit_if.slave  bus,
  output logic [15:0]             total_fines_o,
  output logic [7:0]              drop_count_o
);
  localparam int TBL_N = 2**PLATE_W;

  logic               s1_valid_q;
  logic [PLATE_W-1:0] s1_plate_q;
  logic               s1_road_q;
  logic               s2_valid_q;
  logic [PLATE_W-1:0] s2_plate_q;
  logic               s2_road_q;
  logic [CNT_W-1:0]   s2_cnt_q, s2_cnt_d, s2_cnt_inc;
  logic [CNT_W-1:0]   cnt_tbl_q [TBL_N];
  logic [15:0]        total_q, total_d;
  logic [7:0]         drop_q, drop_d;
  logic [16:0]        total_sum;
  logic [FINE_W-1:0]  s2_fine;
  logic               push_accept;
  ticket_t            push_tkt, head_tkt;

  always_comb begin
    s2_cnt_inc = (s2_cnt_q == '1) ? s2_cnt_q : s2_cnt_q + CNT_W'(1);
    s2_fine    = fine_of(s2_cnt_q);
    // The S2 write lands on the same edge this read is captured, so forward it.
    if (day_clear_i)
      s2_cnt_d = '0;
    else if (s2_valid_q && (s2_plate_q == s1_plate_q))
      s2_cnt_d = s2_cnt_inc;
    else
      s2_cnt_d = cnt_tbl_q[s1_plate_q];
    push_tkt.plate = s2_plate_q;
    push_tkt.road  = s2_road_q;
    push_tkt.fine  = s2_fine;
    total_sum = {1'b0, total_q} + 17'(s2_fine);
    if (day_clear_i)
      total_d = '0;
    else if (push_accept)
      total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    else
      total_d = total_q;
    drop_d = (s2_valid_q && !push_accept && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_plate_q <= '0;
      s1_road_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_plate_q <= '0;
      s2_road_q  <= 1'b0;
      s2_cnt_q   <= '0;
      total_q    <= '0;
      drop_q     <= '0;
      for (int i = 0; i < TBL_N; i++) cnt_tbl_q[i] <= '0;
    end else begin
      s1_valid_q <= bus.viol_valid;
      if (bus.viol_valid) begin
        s1_plate_q <= bus.viol_plate;
        s1_road_q  <= bus.viol_road;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_plate_q <= s1_plate_q;
        s2_road_q  <= s1_road_q;
        s2_cnt_q   <= s2_cnt_d;
      end
      total_q <= total_d;
      drop_q  <= drop_d;
      if (day_clear_i)
        for (int i = 0; i < TBL_N; i++) cnt_tbl_q[i] <= '0;
      else if (s2_valid_q)
        cnt_tbl_q[s2_plate_q] <= s2_cnt_inc;
    end
  end

  ticket_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ticket_t))) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (s2_valid_q),
    .data_i   (push_tkt),
    .ready_i  (bus.tkt_ready),
    .valid_o  (bus.tkt_valid),
    .accept_o (push_accept),
    .data_o   (head_tkt)
  );

  assign bus.tkt_plate  = head_tkt.plate;
  assign bus.tkt_road   = head_tkt.road;
  assign bus.tkt_fine   = head_tkt.fine;
  assign total_fines_o  = total_q;
  assign drop_count_o   = drop_q;
endmodule

// File: tb/tb_violation_ticket_unit.sv
// Bench for violation_ticket_unit: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_violation_ticket_unit;
  import violation_ticket_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        day_clear = 1'b0;
  logic [15:0] total_fines;
  logic [7:0]  drop_count;

  violation_ticket_unit_if vif();

  violation_ticket_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .day_clear_i   (day_clear),
    .bus           (vif),
    .total_fines_o (total_fines),
    .drop_count_o  (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: events complete two edges after entry, in order.
  typedef struct { bit v; int plate; bit road; } ev_t;
  int      m_cnt [32];
  ev_t     m_p1, m_p2;
  ticket_t mq[$];
  ticket_t m_last;
  int      m_tf, m_drop;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      mq.delete();
      m_last = '0;
      m_tf = 0;
      m_drop = 0;
      m_p1 = '{0, 0, 0};
      m_p2 = '{0, 0, 0};
    end else begin
      ticket_t t;
      int c;
      if (mq.size() > 0 && vif.tkt_ready) m_last = mq.pop_front();
      if (m_p2.v) begin
        c = m_cnt[m_p2.plate];
        t.plate = PLATE_W'(m_p2.plate);
        t.road  = m_p2.road;
        t.fine  = FINE_W'(BASE_FINE * (c + 1));
        if (mq.size() < FIFO_DEPTH) begin
          mq.push_back(t);
          m_tf = (m_tf + BASE_FINE * (c + 1) > 65535) ? 65535 : m_tf + BASE_FINE * (c + 1);
        end else begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        if (c < 15) m_cnt[m_p2.plate] = c + 1;
      end
      m_p2 = m_p1;
      m_p1 = '{vif.viol_valid, int'(vif.viol_plate), vif.viol_road};
      if (day_clear) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_tf = 0;
      end
    end
  end

  int got_fines[$];
  int got_plates[$];

  initial forever begin
    ticket_t h;
    @(negedge clk);
    h = (mq.size() > 0) ? mq[0] : m_last;
    chk("tkt_valid", int'(vif.tkt_valid), int'(mq.size() > 0));
    chk("tkt_plate", int'(vif.tkt_plate), int'(h.plate));
    chk("tkt_road", int'(vif.tkt_road), int'(h.road));
    chk("tkt_fine", int'(vif.tkt_fine), int'(h.fine));
    chk("total_fines", int'(total_fines), m_tf);
    chk("drop_count", int'(drop_count), m_drop);
    if (rst_n && vif.tkt_valid && vif.tkt_ready) begin
      got_fines.push_back(int'(vif.tkt_fine));
      got_plates.push_back(int'(vif.tkt_plate));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int plate, input logic road);
    vif.viol_valid = 1'b1;
    vif.viol_plate = PLATE_W'(plate);
    vif.viol_road  = road;
    step(1);
    vif.viol_valid = 1'b0;
  endtask

  task automatic day_pulse();
    day_clear = 1'b1;
    step(1);
    day_clear = 1'b0;
  endtask

  task automatic new_test();
    day_pulse();
    got_fines.delete();
    got_plates.delete();
  endtask

  task automatic chk_fines(input string name, input int exp[$]);
    chk({name, "_n"}, got_fines.size(), exp.size());
    foreach (exp[i]) if (i < got_fines.size()) chk({name, "_fine"}, got_fines[i], exp[i]);
  endtask

  initial begin
    int exp[$];
    vif.viol_valid = 1'b0;
    vif.viol_plate = '0;
    vif.viol_road  = ROAD_A;
    vif.tkt_ready  = 1'b0;
    step(3);
    chk("rst_valid", int'(vif.tkt_valid), 0);
    chk("rst_total", int'(total_fines), 0);
    rst_n = 1'b1;
    step(2);

    // 1: single event, latency and first fine
    new_test();
    vif.tkt_ready = 1'b1;
    ev(5, ROAD_A);
    step(1);
    chk("t1_lat_n1", int'(vif.tkt_valid), 0);
    step(1);
    chk("t1_lat_n2", int'(vif.tkt_valid), 1);
    chk("t1_head_fine", int'(vif.tkt_fine), 10);
    step(2);
    chk_fines("t1", '{10});
    chk("t1_total", int'(total_fines), 10);

    // 2: back-to-back same plate
    new_test();
    repeat (4) ev(9, ROAD_B);
    step(4);
    chk_fines("t2", '{10, 20, 30, 40});
    chk("t2_total", int'(total_fines), 100);

    // 3: counter saturation
    new_test();
    repeat (20) ev(3, ROAD_A);
    step(4);
    exp.delete();
    for (int i = 0; i < 20; i++) exp.push_back(i < 15 ? 10 * (i + 1) : 160);
    chk_fines("t3", exp);
    chk("t3_total", int'(total_fines), 2000);

    // 4: full FIFO drops, then push coinciding with pop while full
    new_test();
    vif.tkt_ready = 1'b0;
    for (int i = 0; i < 10; i++) ev(10 + i, ROAD_B);
    step(3);
    chk("t4_drop", int'(drop_count), 2);
    chk("t4_head", int'(vif.tkt_plate), 10);
    chk("t4_total", int'(total_fines), 80);
    ev(20, ROAD_A);
    step(1);
    vif.tkt_ready = 1'b1;
    step(12);
    chk("t4_n", got_plates.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < got_plates.size()) chk("t4_order", got_plates[i], (i < 8) ? 10 + i : 20);
    chk("t4_drop_after", int'(drop_count), 2);
    chk("t4_total_after", int'(total_fines), 90);

    // 5: day_clear resets offences, FIFO keeps tickets
    new_test();
    vif.tkt_ready = 1'b0;
    ev(4, ROAD_A);
    ev(4, ROAD_A);
    step(3);
    day_pulse();
    ev(4, ROAD_A);
    step(3);
    chk("t5_total", int'(total_fines), 10);
    vif.tkt_ready = 1'b1;
    step(6);
    chk_fines("t5", '{10, 20, 10});

    // 6: reset mid-burst
    new_test();
    vif.tkt_ready = 1'b0;
    ev(1, ROAD_A);
    ev(2, ROAD_A);
    ev(3, ROAD_A);
    step(3);
    vif.viol_valid = 1'b1;
    vif.viol_plate = 5'd6;
    step(1);
    vif.viol_plate = 5'd4;
    step(1);
    vif.viol_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(vif.tkt_valid), 0);
    chk("t6_rst_total", int'(total_fines), 0);
    chk("t6_rst_drop", int'(drop_count), 0);
    step(2);
    vif.tkt_ready = 1'b1;
    rst_n = 1'b1;
    step(1);
    got_fines.delete();
    ev(4, ROAD_B);
    step(4);
    chk_fines("t6", '{10});

    // total_fines saturation
    new_test();
    for (int i = 0; i < 700; i++) ev(i % 4, ROAD_A);
    step(4);
    chk("sat_total", int'(total_fines), 65535);

    // drop_count saturation
    vif.tkt_ready = 1'b0;
    for (int i = 0; i < 300; i++) ev(i % 32, ROAD_B);
    step(4);
    chk("sat_drop", int'(drop_count), 255);
    vif.tkt_ready = 1'b1;
    step(10);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      vif.viol_valid = ($urandom_range(0, 9) < 6);
      vif.viol_plate = PLATE_W'($urandom_range(0, 7));
      vif.viol_road  = $urandom_range(0, 1) == 1;
      vif.tkt_ready  = ($urandom_range(0, 2) != 0);
      day_clear      = ($urandom_range(0, 29) == 0);
      step(1);
    end
    vif.viol_valid = 1'b0;
    day_clear = 1'b0;
    vif.tkt_ready = 1'b1;
    step(12);
    chk("end_empty", int'(vif.tkt_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
